// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and predicts the next fetch address with a
// direct-mapped BTB of 2-bit saturating counters trained by resolved branches.
module if_fetch #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ENABLE,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] IMEM_ADDR,
  output logic [31:0] PC_IF,
  output logic        predict_IF,
  output logic [31:0] npc_pred
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = 32 - IW - 2;

  logic [31:0]   pc_q;
  logic          valid_q  [ENTRIES];
  logic [TW-1:0] tag_q    [ENTRIES];
  logic [31:0]   target_q [ENTRIES];
  logic [1:0]    ctr_q    [ENTRIES];

  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic [IW-1:0] up_idx;
  logic [TW-1:0] up_tag;
  logic          up_hit;
  logic [1:0]    up_ctr;
  logic          unused_upd_bits;

  // Byte-offset bits of a branch address carry no BTB information.
  assign unused_upd_bits = ^upd_pc[1:0];

  always_comb begin
    lk_idx     = pc_q[IW+1:2];
    lk_tag     = pc_q[31:IW+2];
    lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_IF = lk_hit && ctr_q[lk_idx][1];
    npc_pred   = predict_IF ? target_q[lk_idx] : pc_q + 32'd4;
  end

  assign IMEM_ADDR = pc_q;
  assign PC_IF     = pc_q;

  always_comb begin
    up_idx = upd_pc[IW+1:2];
    up_tag = upd_pc[31:IW+2];
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr = ctr_q[up_idx];
    if (upd_taken) begin
      if (up_ctr != 2'b11) up_ctr = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'b00) up_ctr = up_ctr - 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else if (ENABLE) begin
      pc_q <= npc_pred;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i[IW-1:0]] <= 1'b0;
        ctr_q[i[IW-1:0]]   <= 2'b01;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        // A taken miss evicts whatever aliases into this slot.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sequential fetch, stall, BTB allocate/hysteresis,
// alias eviction, redirect/reset priority and PC wrap.
module tb_if_fetch;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ENABLE;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] IMEM_ADDR;
  logic [31:0] PC_IF;
  logic        predict_IF;
  logic [31:0] npc_pred;

  int checks = 0;
  int errors = 0;

  if_fetch #(.ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .redirect(redirect),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .IMEM_ADDR(IMEM_ADDR),
    .PC_IF(PC_IF), .predict_IF(predict_IF), .npc_pred(npc_pred)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc,
                              input logic pred, input logic [31:0] npc);
    check({tag, ".pc"}, PC_IF, pc);
    check({tag, ".addr"}, IMEM_ADDR, pc);
    check({tag, ".pred"}, {31'd0, predict_IF}, {31'd0, pred});
    check({tag, ".npc"}, npc_pred, npc);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    upd_valid = 1'b1; upd_pc = pc; upd_target = tgt; upd_taken = taken;
    step();
    upd_valid = 1'b0;
  endtask

  task automatic go_to(input logic [31:0] pc);
    redirect = 1'b1; redirect_pc = pc;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; ENABLE = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;

    // Reset and sequential fetch
    step(); step();
    expect_fetch("reset", 32'h0, 1'b0, 32'h4);
    RST_N = 1'b1; ENABLE = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_fetch("seq", 32'(i * 4), 1'b0, 32'(i * 4 + 4));
    end

    // Stall then resume
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc", PC_IF, 32'h10);
    end
    ENABLE = 1'b1;
    step();
    check("resume.pc", PC_IF, 32'h14);
    ENABLE = 1'b0;

    // Allocate 0x20 -> 0x100, fetch through it
    train(32'h20, 32'h100, 1'b1);
    check("alloc.hold", PC_IF, 32'h14);
    go_to(32'h1C);
    expect_fetch("pre_branch", 32'h1C, 1'b0, 32'h20);
    ENABLE = 1'b1;
    step();
    expect_fetch("alloc_hit", 32'h20, 1'b1, 32'h100);
    step();
    expect_fetch("taken_target", 32'h100, 1'b0, 32'h104);
    ENABLE = 1'b0;

    // Hysteresis: not-taken (10->01) with a simultaneous redirect to 0x20
    upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h100; upd_taken = 1'b0;
    go_to(32'h20);
    upd_valid = 1'b0;
    expect_fetch("ctr01", 32'h20, 1'b0, 32'h24);
    train(32'h20, 32'h100, 1'b1);
    expect_fetch("ctr10", 32'h20, 1'b1, 32'h100);
    train(32'h20, 32'h100, 1'b1);
    check("ctr11.pred", {31'd0, predict_IF}, 32'd1);
    for (int i = 0; i < 3; i++) train(32'h20, 32'h100, 1'b1);
    check("ctr_sat_hi.pred", {31'd0, predict_IF}, 32'd1);
    train(32'h20, 32'h100, 1'b0);
    check("ctr11_to_10.pred", {31'd0, predict_IF}, 32'd1);
    train(32'h20, 32'h100, 1'b0);
    check("ctr10_to_01.pred", {31'd0, predict_IF}, 32'd0);
    train(32'h20, 32'h100, 1'b0);
    train(32'h20, 32'h100, 1'b0);
    train(32'h20, 32'h100, 1'b1);
    check("ctr_sat_lo.pred", {31'd0, predict_IF}, 32'd0);
    train(32'h20, 32'h200, 1'b1);
    expect_fetch("ctr_new_target", 32'h20, 1'b1, 32'h200);

    // Same-cycle update and lookup on one entry sees pre-update contents
    upd_valid = 1'b1; upd_pc = 32'h20; upd_target = 32'h100; upd_taken = 1'b0;
    #1;
    check("same_cycle.pred", {31'd0, predict_IF}, 32'd1);
    step();
    upd_valid = 1'b0;
    check("after_update.pred", {31'd0, predict_IF}, 32'd0);

    // Alias eviction: 0x60 shares index 8 with 0x20
    train(32'h20, 32'h100, 1'b1);
    check("realloc.pred", {31'd0, predict_IF}, 32'd1);
    train(32'h60, 32'h300, 1'b1);
    expect_fetch("evicted", 32'h20, 1'b0, 32'h24);
    train(32'hA0, 32'h400, 1'b0);
    go_to(32'h60);
    expect_fetch("alias_hit", 32'h60, 1'b1, 32'h300);
    ENABLE = 1'b1;
    step();
    check("alias_target.pc", PC_IF, 32'h300);

    // Redirect beats stall, and beats ENABLE
    ENABLE = 1'b0;
    go_to(32'h200);
    check("redirect_stall.pc", PC_IF, 32'h200);
    ENABLE = 1'b1;
    go_to(32'h60);
    expect_fetch("redirect_enable", 32'h60, 1'b1, 32'h300);
    ENABLE = 1'b0;

    // Reset dominates redirect and training; BTB cleared
    RST_N = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    upd_valid = 1'b1; upd_pc = 32'h40; upd_target = 32'h500; upd_taken = 1'b1;
    step();
    redirect = 1'b0; upd_valid = 1'b0;
    expect_fetch("reset_dom", 32'h0, 1'b0, 32'h4);
    RST_N = 1'b1;
    go_to(32'h60);
    expect_fetch("cleared_60", 32'h60, 1'b0, 32'h64);
    go_to(32'h40);
    expect_fetch("no_train_in_reset", 32'h40, 1'b0, 32'h44);

    // PC+4 wraps modulo 2^32
    go_to(32'hFFFF_FFFC);
    expect_fetch("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    ENABLE = 1'b1;
    step();
    check("wrap.pc", PC_IF, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
